// File: rtl/scie_unpipelined.sv
`default_nettype none
// ============================================================================
// Module   : scie_unpipelined
// Purpose  : Single-cycle SCIE custom-3 datapath. It decodes the instruction
//            word and applies a signed/unsigned min/max, a saturating absolute
//            value, or a saturating add/sub to rs1/rs2, all within one cycle.
//            It holds no state. Clock and reset exist only so the ports match
//            the SCIE interface.
// Revision : 1.0 - initial release
// ============================================================================
module scie_unpipelined #(
  parameter int unsigned XLEN   = 32,
  parameter logic [6:0]  OPCODE = 7'h7B
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     io_insn,
  input  logic [XLEN-1:0] io_rs1,
  input  logic [XLEN-1:0] io_rs2,
  output logic [XLEN-1:0] io_rd
);

  localparam logic [XLEN-1:0] C_SMAX = {1'b0, {(XLEN-1){1'b1}}};
  localparam logic [XLEN-1:0] C_SMIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] C_OP_SMAX  = 3'd0;
  localparam logic [2:0] C_OP_SMIN  = 3'd1;
  localparam logic [2:0] C_OP_UMAX  = 3'd2;
  localparam logic [2:0] C_OP_UMIN  = 3'd3;
  localparam logic [2:0] C_OP_SABS  = 3'd4;
  localparam logic [2:0] C_OP_SADDS = 3'd5;
  localparam logic [2:0] C_OP_SSUBS = 3'd6;

  // Clock, reset and the register-index fields play no part in the result.
  // They are gathered here only so that they are visibly consumed.
  logic w_unused;
  assign w_unused = &{1'b0, clock, reset, io_insn[24:15], io_insn[11:7]};

  logic            w_valid;
  logic [2:0]      w_funct3;
  logic            w_s_gt, w_s_lt, w_u_gt, w_u_lt;
  logic [XLEN:0]   w_sum, w_diff;
  logic [XLEN-1:0] w_abs, w_adds, w_subs;

  assign w_valid  = (io_insn[6:0] == OPCODE) && (io_insn[31:25] == 7'd0);
  assign w_funct3 = io_insn[14:12];

  assign w_s_gt = $signed(io_rs1) > $signed(io_rs2);
  assign w_s_lt = $signed(io_rs1) < $signed(io_rs2);
  assign w_u_gt = io_rs1 > io_rs2;
  assign w_u_lt = io_rs1 < io_rs2;

  // Both operands are sign-extended by one bit. The true result can then be
  // read in full, and overflow shows up as the top two bits disagreeing. The
  // top bit is the true sign, so it tells us which way to clamp.
  assign w_sum  = {io_rs1[XLEN-1], io_rs1} + {io_rs2[XLEN-1], io_rs2};
  assign w_diff = {io_rs1[XLEN-1], io_rs1} - {io_rs2[XLEN-1], io_rs2};

  assign w_adds = (w_sum[XLEN] != w_sum[XLEN-1])
                ? (w_sum[XLEN] ? C_SMIN : C_SMAX) : w_sum[XLEN-1:0];
  assign w_subs = (w_diff[XLEN] != w_diff[XLEN-1])
                ? (w_diff[XLEN] ? C_SMIN : C_SMAX) : w_diff[XLEN-1:0];

  // The most negative value has no positive counterpart, so it saturates.
  assign w_abs = (io_rs1 == C_SMIN) ? C_SMAX
               : (io_rs1[XLEN-1] ? (~io_rs1 + 1'b1) : io_rs1);

  // Result select. An invalid decode or a reserved funct3 drives zero.
  always_comb begin
    io_rd = '0;
    if (w_valid) begin
      case (w_funct3)
        C_OP_SMAX:  io_rd = w_s_gt ? io_rs1 : io_rs2;
        C_OP_SMIN:  io_rd = w_s_lt ? io_rs1 : io_rs2;
        C_OP_UMAX:  io_rd = w_u_gt ? io_rs1 : io_rs2;
        C_OP_UMIN:  io_rd = w_u_lt ? io_rs1 : io_rs2;
        C_OP_SABS:  io_rd = w_abs;
        C_OP_SADDS: io_rd = w_adds;
        C_OP_SSUBS: io_rd = w_subs;
        default:    io_rd = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scie_unpipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_scie_unpipelined
// Purpose  : Directed self-checking bench for scie_unpipelined. Each vector
//            carries an expected result worked out by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scie_unpipelined;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] io_insn = 32'h0;
  logic [31:0] io_rs1 = 32'h0;
  logic [31:0] io_rs2 = 32'h0;
  logic [31:0] io_rd;

  int n_cmp = 0;
  int n_bad = 0;

  scie_unpipelined #(.XLEN(32), .OPCODE(7'h7B)) dut (
    .clock   (clock),
    .reset   (reset),
    .io_insn (io_insn),
    .io_rs1  (io_rs1),
    .io_rs2  (io_rs2),
    .io_rd   (io_rd)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] exp);
    n_cmp++;
    assert (io_rd === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, io_rd, exp);
    end
  endtask

  // Drive on the falling edge and sample 2 time units later, well away from either clock edge.
  task automatic vec(input string tag, input logic [31:0] insn,
                     input logic [31:0] rs1, input logic [31:0] rs2,
                     input logic [31:0] exp);
    @(negedge clock);
    io_insn = insn;
    io_rs1  = rs1;
    io_rs2  = rs2;
    #2;
    check(tag, exp);
  endtask

  initial begin
    // Checks at t=1, before any clock edge: the output depends on the inputs alone.
    io_insn = 32'h0000_007B; io_rs1 = 32'd39; io_rs2 = 32'd0;
    #1;
    check("pre_clk_relu39", 32'd39);
    io_insn = 32'h0000_0033; io_rs1 = 32'd7;
    #1;
    check("pre_clk_badop", 32'd0);

    // SMAX against zero behaves as ReLU.
    vec("relu_7",   32'h7B, 32'd7,  32'd0, 32'd7);
    vec("relu_39",  32'h7B, 32'd39, 32'd0, 32'd39);
    vec("relu_35",  32'h7B, 32'd35, 32'd0, 32'd35);
    vec("relu_11",  32'h7B, 32'd11, 32'd0, 32'd11);
    vec("relu_1",   32'h7B, 32'd1,  32'd0, 32'd1);
    vec("relu_0",   32'h7B, 32'd0,  32'd0, 32'd0);
    vec("relu_49",  32'h7B, 32'd49, 32'd0, 32'd49);
    vec("relu_m11", 32'h7B, -32'sd11, 32'd0, 32'd0);
    vec("relu_m26", 32'h7B, -32'sd26, 32'd0, 32'd0);
    vec("relu_m46", 32'h7B, -32'sd46, 32'd0, 32'd0);
    vec("relu_m1",  32'h7B, -32'sd1,  32'd0, 32'd0);
    vec("relu_m48", 32'h7B, -32'sd48, 32'd0, 32'd0);

    // Min/max: signed and unsigned compares disagree on negative operands.
    vec("smin_m5_3",  32'h107B, -32'sd5, 32'd3, 32'hFFFF_FFFB);
    vec("umax_m1_3",  32'h207B, -32'sd1, 32'd3, 32'hFFFF_FFFF);
    vec("umin_m1_3",  32'h307B, -32'sd1, 32'd3, 32'd3);
    vec("smax_3_m5",  32'h007B, 32'd3, -32'sd5, 32'd3);
    vec("umax_m1_0",  32'h207B, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
    vec("umin_m1_0",  32'h307B, 32'hFFFF_FFFF, 32'd0, 32'd0);
    vec("smin_m1_0",  32'h107B, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
    vec("smax_eq",    32'h007B, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
    vec("umin_eq",    32'h307B, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001);

    // Absolute value, including the most negative input.
    vec("sabs_m41",   32'h407B, -32'sd41, 32'hDEAD_BEEF, 32'd41);
    vec("sabs_pos",   32'h407B, 32'd17, 32'd0, 32'd17);
    vec("sabs_min",   32'h407B, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF);

    // Saturating add and subtract.
    vec("sadds_posov", 32'h507B, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF);
    vec("ssubs_negov", 32'h607B, 32'h8000_0000, 32'd1, 32'h8000_0000);
    vec("sadds_5_m7",  32'h507B, 32'd5, -32'sd7, 32'hFFFF_FFFE);
    vec("sadds_negov", 32'h507B, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    vec("ssubs_posov", 32'h607B, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
    vec("ssubs_5_7",   32'h607B, 32'd5, 32'd7, 32'hFFFF_FFFE);
    vec("sadds_mixed", 32'h507B, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF);

    // Invalid decodes all drive zero.
    vec("bad_opcode",  32'h0000_0033, 32'd7, 32'd0, 32'd0);
    vec("bad_funct7",  32'h0200_007B, 32'd7, 32'd0, 32'd0);
    vec("reserved_f3", 32'h0000_707B, 32'd7, 32'd3, 32'd0);

    // Reset toggled mid-stream leaves the combinational result untouched.
    vec("rst_pre", 32'h7B, 32'd39, 32'd0, 32'd39);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_assert", 32'd39);
    @(posedge clock);
    #1;
    check("rst_held_edge", 32'd39);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_release", 32'd39);
    @(posedge clock);
    #1;
    check("rst_after_edge", 32'd39);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
